// File: rtl/router_1ton_buffered.sv
// -----------------------------------------------------------------------------
// router_1ton_buffered
//
// Buffered 1-to-N stream router. One producer presents a beat (payload plus
// destination index) on a valid/ready input. The beat is steered into the FIFO
// of the addressed output port. Each port drains through its own valid/ready
// output, so a stalled sink only holds back beats addressed to it.
//
// Handshake rule (input and every output port): a beat moves on a rising clock
// edge exactly when valid and ready are both high at that edge. A producer
// keeps its payload stable while valid is high and ready is low. Ready never
// depends on valid.
//
// Parameters
//   DATA_W     payload width in bits (>=1)
//   NUM_PORTS  number of output channels (>=2, any value)
//   DEPTH      entries per output FIFO (power of 2, >=2)
//   DEST_W     derived: $clog2(NUM_PORTS), not overridable
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset, empties every FIFO
//   in_data    input payload
//   in_dest    destination port index
//   in_valid   input beat present
//   in_ready   router accepts the beat this cycle
//   out_data   port p payload at [p*DATA_W +: DATA_W], zero when port p is idle
//   out_valid  port p has a head entry
//   out_ready  port p sink takes the head entry
//   port_full  port p FIFO holds DEPTH entries
//   drop_cnt   (only with ROUTER_DROP_CNT_EN) saturating count of beats
//              discarded because in_dest >= NUM_PORTS
//
// Build option
//   ROUTER_DROP_CNT_EN  when defined, adds the drop_cnt output.
// -----------------------------------------------------------------------------
module router_1ton_buffered #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_PORTS = 8,
  parameter  int DEPTH     = 4,
  localparam int DEST_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [DEST_W-1:0]           in_dest,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        port_full
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // An index that names no port is still accepted so the producer never
  // stalls on a bad address; the beat is simply thrown away.
  logic dest_ok;
  logic sel_full;

  assign dest_ok = (32'(in_dest) < 32'(NUM_PORTS));

  // Look up the addressed port's full flag without indexing past the vector
  // when the destination is out of range.
  always_comb begin
    sel_full = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_dest == DEST_W'(p)) begin
        sel_full = port_full[p];
      end
    end
  end

  // Based on registered counts only: a full FIFO popping this cycle still
  // refuses the incoming beat, which keeps in_ready off the out_ready path.
  assign in_ready = !dest_ok || !sel_full;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    assign push = in_valid && dest_ok && (in_dest == DEST_W'(p)) &&
                  (count != FULL_CNT);
    // An empty FIFO never pops, even if a beat is being pushed right now:
    // there is no bypass, so a fresh beat appears one cycle after acceptance.
    assign pop  = (count != '0) && out_ready[p];

    // Storage carries no reset; stale entries are hidden by the output mask.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= in_data;
      end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
          count <= count - (PTR_W+1)'(1);
        end
      end
    end

    assign out_valid[p] = (count != '0);
    assign port_full[p] = (count == FULL_CNT);
    assign out_data[p*DATA_W +: DATA_W] = (count != '0) ? mem[rd_ptr] : '0;
  end

`ifdef ROUTER_DROP_CNT_EN
  // Only beats actually discarded are counted; a beat held off by
  // in_ready=0 is not a drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_valid && !dest_ok && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
